// File: rtl/hazard_pkg.sv
// Shared Tnew encodings, table entry and query types for the hazard scoreboard.
package hazard_pkg;
    localparam int SB_TNEW_W  = 3;
    localparam int SB_DEPTH   = 4;
    localparam int SB_ISSUE_W = 2;
    localparam int SB_AGE_W   = $clog2(SB_DEPTH);
    localparam int SB_LANE_W  = (SB_ISSUE_W > 1) ? $clog2(SB_ISSUE_W) : 1;

    localparam logic [SB_TNEW_W-1:0] TNEW_ALU       = 3'd0;
    localparam logic [SB_TNEW_W-1:0] TNEW_MEM       = 3'd1;
    localparam logic [SB_TNEW_W-1:0] TNEW_MDU       = 3'd2;
    localparam logic [SB_TNEW_W-1:0] TNEW_CP0       = 3'd3;
    localparam logic [SB_TNEW_W-1:0] TNEW_BRU       = 3'd4;
    localparam logic [SB_TNEW_W-1:0] TNEW_STALL     = 3'd6;
    localparam logic [SB_TNEW_W-1:0] TNEW_NOT_WRITE = 3'd7;

    typedef struct packed {
        logic                 busy;
        logic [SB_TNEW_W-1:0] cnt;
        logic [SB_AGE_W-1:0]  age;
        logic [SB_LANE_W-1:0] lane;
    } sb_entry_t;

    typedef struct packed {
        logic [4:0]           addr;
        logic [SB_TNEW_W-1:0] tuse;
    } sb_query_t;

    // One pipeline step of a result countdown; unforwardable results stay pinned.
    function automatic logic [SB_TNEW_W-1:0] cnt_age(input logic [SB_TNEW_W-1:0] cnt);
        if (cnt == TNEW_STALL) begin
            cnt_age = TNEW_STALL;
        end else if (cnt == 3'd0) begin
            cnt_age = 3'd0;
        end else begin
            cnt_age = cnt - 3'd1;
        end
    endfunction
endpackage

// File: rtl/sb_query_port.sv
// One source-operand lookup: table entry in, stall or forward selection out.
module sb_query_port
    import hazard_pkg::*;
(
    input  sb_entry_t            entry_i,
    input  sb_query_t            query_i,
    output logic                 stall_o,
    output logic                 fwd_valid_o,
    output logic [SB_AGE_W-1:0]  fwd_age_o,
    output logic [SB_LANE_W-1:0] fwd_lane_o
);

    // A producer is usable only if its countdown finishes by the time the operand is consumed.
    always_comb begin
        stall_o     = 1'b0;
        fwd_valid_o = 1'b0;
        fwd_age_o   = {SB_AGE_W{1'b0}};
        fwd_lane_o  = {SB_LANE_W{1'b0}};
        if ((query_i.addr != 5'd0) && entry_i.busy) begin
            if ((entry_i.cnt == TNEW_STALL) || (entry_i.cnt > query_i.tuse)) begin
                stall_o = 1'b1;
            end else begin
                fwd_valid_o = 1'b1;
                fwd_age_o   = entry_i.age;
                fwd_lane_o  = entry_i.lane;
            end
        end else begin
            stall_o = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown table of in-flight writes answering stall/forward queries.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ISSUE_WIDTH = SB_ISSUE_W,
    parameter int NUM_QUERY   = 4,
    parameter int NUM_REGS    = 32,
    parameter int DEPTH       = SB_DEPTH,
    parameter int TNEW_W      = SB_TNEW_W
) (
    input  logic                                          clk,
    input  logic                                          resetn,
    input  logic                                          pipe_adv,
    input  logic [ISSUE_WIDTH-1:0]                        issue_valid,
    input  logic [ISSUE_WIDTH-1:0][4:0]                   issue_waddr,
    input  logic [ISSUE_WIDTH-1:0][TNEW_W-1:0]            issue_tnew,
    input  logic                                          flush,
    input  logic [$clog2(DEPTH+1)-1:0]                    flush_age,
    input  logic [NUM_QUERY-1:0][4:0]                     q_addr,
    input  logic [NUM_QUERY-1:0][TNEW_W-1:0]              q_tuse,
    output logic [NUM_QUERY-1:0]                          q_stall,
    output logic [NUM_QUERY-1:0]                          q_fwd_valid,
    output logic [NUM_QUERY-1:0][$clog2(DEPTH)-1:0]       q_fwd_age,
    output logic [NUM_QUERY-1:0][$clog2(ISSUE_WIDTH)-1:0] q_fwd_lane,
    output logic                                          stall_any
);

    localparam int FA_W = $clog2(DEPTH+1);

    sb_entry_t                table_q [NUM_REGS];
    sb_entry_t                table_d [NUM_REGS];
    logic [ISSUE_WIDTH-1:0]   alloc_s;
    sb_query_t                query_s [NUM_QUERY];

    // Lanes that really allocate this edge; a flush suppresses all allocation.
    always_comb begin
        alloc_s = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            alloc_s[i] = pipe_adv && !flush && issue_valid[i] &&
                         (issue_waddr[i] != 5'd0) && (issue_tnew[i] != TNEW_NOT_WRITE);
        end
    end

    // Next table: flush clears young entries, otherwise age/retire, then allocation overrides.
    always_comb begin
        logic                 hit_v;
        logic [SB_LANE_W-1:0] lane_v;
        logic [TNEW_W-1:0]    tnew_v;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r == 0) begin
                table_d[r] = '0;
            end else if (flush && table_q[r].busy && (FA_W'(table_q[r].age) < flush_age)) begin
                table_d[r] = '0;
            end else if (pipe_adv && table_q[r].busy) begin
                if (table_q[r].age == SB_AGE_W'(DEPTH-1)) begin
                    table_d[r] = '0;
                end else begin
                    table_d[r]      = table_q[r];
                    table_d[r].age  = table_q[r].age + SB_AGE_W'(1);
                    table_d[r].cnt  = cnt_age(table_q[r].cnt);
                end
            end else begin
                table_d[r] = table_q[r];
            end

            // Later lanes override earlier ones writing the same register.
            hit_v  = 1'b0;
            lane_v = {SB_LANE_W{1'b0}};
            tnew_v = {TNEW_W{1'b0}};
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (alloc_s[i] && (issue_waddr[i] == 5'(r))) begin
                    hit_v  = 1'b1;
                    lane_v = SB_LANE_W'(i);
                    tnew_v = issue_tnew[i];
                end else begin
                    hit_v  = hit_v;
                end
            end
            if (hit_v && (r != 0)) begin
                table_d[r] = '{busy: 1'b1, cnt: tnew_v, age: {SB_AGE_W{1'b0}}, lane: lane_v};
            end else begin
                table_d[r] = table_d[r];
            end
        end
    end

    // Table state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                table_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                table_q[r] <= table_d[r];
            end
        end
    end

    for (genvar p = 0; p < NUM_QUERY; p++) begin : g_query
        assign query_s[p] = '{addr: q_addr[p], tuse: q_tuse[p]};

        sb_query_port u_query (
            .entry_i     (table_q[q_addr[p]]),
            .query_i     (query_s[p]),
            .stall_o     (q_stall[p]),
            .fwd_valid_o (q_fwd_valid[p]),
            .fwd_age_o   (q_fwd_age[p]),
            .fwd_lane_o  (q_fwd_lane[p])
        );
    end

    assign stall_any = |q_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: in-flight-write list model checked every cycle plus literal checks.
module tb_hazard_scoreboard;
    localparam int IW = 2, NQ = 4, DEPTH = 4, TW = 3;
    localparam int T_STALL = 6, T_NW = 7;

    logic                   clk = 1'b0, clk_en = 1'b1, resetn = 1'b0;
    logic                   pipe_adv = 1'b0, flush = 1'b0;
    logic [IW-1:0]          issue_valid = '0;
    logic [IW-1:0][4:0]     issue_waddr = '0;
    logic [IW-1:0][TW-1:0]  issue_tnew = '0;
    logic [2:0]             flush_age = '0;
    logic [NQ-1:0][4:0]     q_addr = '0;
    logic [NQ-1:0][TW-1:0]  q_tuse = '0;
    logic [NQ-1:0]          q_stall, q_fwd_valid;
    logic [NQ-1:0][1:0]     q_fwd_age;
    logic [NQ-1:0][0:0]     q_fwd_lane;
    logic                   stall_any;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    hazard_scoreboard dut (
        .clk(clk), .resetn(resetn), .pipe_adv(pipe_adv),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_tnew(issue_tnew),
        .flush(flush), .flush_age(flush_age),
        .q_addr(q_addr), .q_tuse(q_tuse),
        .q_stall(q_stall), .q_fwd_valid(q_fwd_valid),
        .q_fwd_age(q_fwd_age), .q_fwd_lane(q_fwd_lane),
        .stall_any(stall_any)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Model: list of in-flight writes, at most one live write per register.
    typedef struct { int rd; int cnt; int age; int lane; } wr_t;
    wr_t mdl[$];

    function automatic void mdl_step();
        wr_t nq[$];
        wr_t kq[$];
        wr_t w;
        bit keep;
        foreach (mdl[k]) begin
            w = mdl[k];
            keep = 1'b1;
            if (flush && (w.age < int'(flush_age))) keep = 1'b0;
            else if (pipe_adv) begin
                w.age = w.age + 1;
                if (w.age >= DEPTH) keep = 1'b0;
                if (w.cnt != T_STALL && w.cnt > 0) w.cnt = w.cnt - 1;
            end
            if (keep) nq.push_back(w);
        end
        if (pipe_adv && !flush) begin
            for (int i = 0; i < IW; i++) begin
                if (issue_valid[i] && issue_waddr[i] != 5'd0 && int'(issue_tnew[i]) != T_NW) begin
                    kq.delete();
                    foreach (nq[k]) if (nq[k].rd != int'(issue_waddr[i])) kq.push_back(nq[k]);
                    kq.push_back('{rd: int'(issue_waddr[i]), cnt: int'(issue_tnew[i]), age: 0, lane: i});
                    nq = kq;
                end
            end
        end
        mdl = nq;
    endfunction

    function automatic void mdl_q(input int addr, input int tuse,
                                  output int st, output int fv, output int ag, output int ln);
        st = 0; fv = 0; ag = 0; ln = 0;
        if (addr != 0) begin
            foreach (mdl[k]) begin
                if (mdl[k].rd == addr) begin
                    if (mdl[k].cnt == T_STALL || mdl[k].cnt > tuse) st = 1;
                    else begin fv = 1; ag = mdl[k].age; ln = mdl[k].lane; end
                end
            end
        end
    endfunction

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) mdl.delete();
        else mdl_step();
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    initial forever begin
        int st, fv, ag, ln, anys;
        @(negedge clk);
        if (cmp_en && resetn) begin
            anys = 0;
            for (int p = 0; p < NQ; p++) begin
                mdl_q(int'(q_addr[p]), int'(q_tuse[p]), st, fv, ag, ln);
                anys = anys | st;
                chk($sformatf("cmp_p%0d_stall", p), int'(q_stall[p]), st);
                chk($sformatf("cmp_p%0d_fwd_valid", p), int'(q_fwd_valid[p]), fv);
                if (fv != 0) begin
                    chk($sformatf("cmp_p%0d_fwd_age", p), int'(q_fwd_age[p]), ag);
                    chk($sformatf("cmp_p%0d_fwd_lane", p), int'(q_fwd_lane[p]), ln);
                end
            end
            chk("cmp_stall_any", int'(stall_any), anys);
        end
    end

    task automatic hq(input int p, input int st, input int fv, input int ag, input int ln, input string tag);
        chk({tag, "_stall"}, int'(q_stall[p]), st);
        chk({tag, "_fwd_valid"}, int'(q_fwd_valid[p]), fv);
        if (fv != 0) begin
            chk({tag, "_fwd_age"}, int'(q_fwd_age[p]), ag);
            chk({tag, "_fwd_lane"}, int'(q_fwd_lane[p]), ln);
        end
    endtask

    task automatic setq(input int p, input int addr, input int tuse);
        q_addr[p] = 5'(addr);
        q_tuse[p] = 3'(tuse);
    endtask

    task automatic issue(input int lane, input int rd, input int tnew);
        issue_valid[lane] = 1'b1;
        issue_waddr[lane] = 5'(rd);
        issue_tnew[lane]  = 3'(tnew);
    endtask

    task automatic tick(input bit adv);
        pipe_adv = adv;
        @(posedge clk);
        #1;
        pipe_adv = 1'b0; issue_valid = '0; flush = 1'b0; flush_age = 3'd0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1; cmp_en = 1'b1;

        setq(0, 5, 0); setq(1, 8, 0); setq(2, 3, 0); setq(3, 9, 7); #1;
        for (int p = 0; p < NQ; p++) hq(p, 0, 0, 0, 0, "reset");
        chk("reset_stall_any", int'(stall_any), 0);

        issue(0, 5, 0); tick(1); #1;
        hq(0, 0, 1, 0, 0, "alu_fwd");

        issue(0, 8, 1); tick(1); setq(2, 8, 1); #1;
        hq(1, 1, 0, 0, 0, "loaduse_stall");
        hq(2, 0, 1, 0, 0, "loaduse_tuse1");
        hq(0, 0, 1, 1, 0, "alu_age1");
        chk("loaduse_stall_any", int'(stall_any), 1);
        tick(1); #1; hq(1, 0, 1, 1, 0, "loaduse_fwd");
        tick(1); tick(1); #1; hq(1, 0, 1, 3, 0, "loaduse_age3");
        tick(1); #1; hq(1, 0, 0, 0, 0, "loaduse_retired");

        issue(0, 3, 0); issue(1, 3, 0); tick(1); setq(2, 3, 0); #1;
        hq(2, 0, 1, 0, 1, "dual_lane");
        issue(0, 4, 0); tick(0); tick(0); tick(0); setq(0, 4, 7); #1;
        hq(2, 0, 1, 0, 1, "hold_age");
        hq(0, 0, 0, 0, 0, "no_adv_no_alloc");

        issue(1, 9, 6); tick(1); setq(3, 9, 0);
        for (int t = 0; t < 8; t++) begin
            q_tuse[3] = 3'(t); #1;
            hq(3, 1, 0, 0, 0, $sformatf("movz_tuse%0d", t));
        end
        chk("movz_stall_any", int'(stall_any), 1);
        for (int k = 0; k < 3; k++) begin
            tick(1); #1; hq(3, 1, 0, 0, 0, $sformatf("movz_adv%0d", k + 2));
        end
        tick(1); #1; hq(3, 0, 0, 0, 0, "movz_retired");

        issue(0, 3, 0); tick(1); issue(0, 2, 0); tick(1); issue(0, 1, 0); tick(1);
        setq(0, 1, 7); setq(1, 2, 7); setq(2, 3, 7); setq(3, 7, 7); #1;
        hq(0, 0, 1, 0, 0, "pre_flush_r1");
        hq(1, 0, 1, 1, 0, "pre_flush_r2");
        hq(2, 0, 1, 2, 0, "pre_flush_r3");
        flush = 1'b1; flush_age = 3'd2; issue(1, 7, 0); tick(1); #1;
        hq(0, 0, 0, 0, 0, "flush_r1");
        hq(1, 0, 0, 0, 0, "flush_r2");
        hq(2, 0, 1, 3, 0, "flush_keep_r3");
        hq(3, 0, 0, 0, 0, "flush_no_alloc");

        issue(0, 10, 0); issue(1, 11, 0); tick(1);
        issue(0, 12, 0); issue(1, 13, 0); tick(1);
        issue(0, 14, 0); tick(1);
        setq(0, 10, 7); setq(1, 11, 7); setq(2, 12, 7); setq(3, 13, 7); #1;
        hq(0, 0, 1, 2, 0, "prerst_r10");
        hq(1, 0, 1, 2, 1, "prerst_r11");
        hq(2, 0, 1, 1, 0, "prerst_r12");
        hq(3, 0, 1, 1, 1, "prerst_r13");
        clk_en = 1'b0;
        #3; resetn = 1'b0; #1;
        for (int p = 0; p < NQ; p++) hq(p, 0, 0, 0, 0, $sformatf("async_reset_p%0d", p));
        chk("async_reset_stall_any", int'(stall_any), 0);
        #5; resetn = 1'b1; #2; clk_en = 1'b1;

        // Mixed sweep checked by the model.
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < IW; i++) begin
                issue_valid[i] = 1'($urandom_range(0, 1));
                issue_waddr[i] = 5'($urandom_range(0, 12));
                issue_tnew[i]  = 3'($urandom_range(0, 7));
            end
            flush     = ($urandom_range(0, 7) == 0);
            flush_age = 3'($urandom_range(0, 4));
            for (int p = 0; p < NQ; p++) setq(p, $urandom_range(0, 12), $urandom_range(0, 7));
            tick(1'($urandom_range(0, 3) != 0));
        end
        tick(0); tick(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
